unary_stream_gen: RTL and testbench
===================================

UNARY_STREAM_GEN -- requirements
Module: unary_stream_gen

Interface
- REQ-001: Parameter W, default 4, is the binary operand width.
- REQ-002: Parameter LEN, default 14, is the unary stream length in cycles; legal range 1..2^W-1.
- REQ-003: Parameter WR_CYC, default 20, is the number of cycles the write phase is held.
- REQ-004: Ports shall be:
  - clk  in  1  clock; single clock domain, all logic on its rising edge.
  - rst  in  1  reset; synchronous, active-high.
  - start  in  1  request to encode one operand pair.
  - a_val  in  W  operand A, binary.
  - b_val  in  W  operand B, binary.
  - A  out  1  unary (thermometer) stream A to the downstream adder.
  - B  out  1  unary (thermometer) stream B to the downstream adder.
  - en  out  1  downstream enable.
  - read_or_write  out  1  downstream mode: 0 = read/accumulate, 1 = write-out.
  - busy  out  1  high while a transaction is in progress.
  - done  out  1  one-cycle pulse at transaction end.
  - err  out  1  one-cycle pulse when an operand is out of range.

Function
- REQ-005: FSM states shall be IDLE, STREAM, WRITE and FIN; all outputs shall be registered.
- REQ-006: In IDLE, start=1 at an edge shall capture a_val/b_val into a_q/b_q, clear the cycle counter and enter STREAM; start=0 shall remain in IDLE.
- REQ-007: In STREAM cycle i (i=0..LEN-1): A=(i<a_q), B=(i<b_q), en=1, read_or_write=0.
  - Ones come first, then zeros.
  - The first stream cycle is the cycle immediately after the start edge.
- REQ-008: After stream cycle LEN-1, the FSM shall enter WRITE for exactly WR_CYC cycles: en=1, read_or_write=1, A=0, B=0.
- REQ-009: After the last WRITE cycle, the FSM shall enter FIN for one cycle: done=1, en=0, read_or_write=0, A=0, B=0; it shall then return to IDLE.
- REQ-010: busy shall be 1 in STREAM and WRITE and 0 in IDLE and FIN.
- REQ-011: Total latency from the start edge to the done pulse shall be LEN+WR_CYC cycles.
- REQ-012: start shall be ignored outside IDLE, and a_val/b_val changes after capture shall have no effect.
- REQ-013: Operand 0 shall produce an all-zero stream; operand LEN shall produce an all-one stream.
- REQ-014: The counter width shall be clog2(max(LEN,WR_CYC)+1) and the counter shall never wrap within a phase.
- REQ-015: Out-of-range handling (a_val>LEN or b_val>LEN) shall be as specified under Configuration.

Reset
- REQ-016: rst=1 at an edge shall force IDLE and clear A, B, en, read_or_write, busy, done, err, the counter, a_q and b_q, with priority over all other inputs.
- REQ-017: rst asserted mid-STREAM or mid-WRITE shall abort the transaction with no done pulse; outputs shall be 0 from the next cycle.
- REQ-018: start sampled in the same cycle as rst shall be discarded.

Configuration
- REQ-019: With UNARY_GEN_SAT_EN defined, an out-of-range operand shall be clamped to LEN at capture and err shall pulse in the first STREAM cycle; the transaction shall proceed normally.
- REQ-020: Without UNARY_GEN_SAT_EN, an out-of-range start shall be rejected: err shall pulse one cycle after the start edge, the FSM shall stay in IDLE, and en/busy shall stay 0.

Verification (LEN=14, WR_CYC=20)
- REQ-021: a_val=13, b_val=14, start pulse -> A=1 for stream cycles 0..12 and 0 at cycle 13; B=1 for cycles 0..13; read_or_write=1 for 20 cycles; done exactly 34 cycles after the start edge.
- REQ-022: a_val=0, b_val=0 -> A=B=0 throughout with en=1 for 34 cycles; a_val=14, b_val=7 -> A=1 for 14 cycles, B=1 for 7 cycles.
- REQ-023: a_val=15, b_val=3 -> with the macro: A=1 for all 14 stream cycles and err pulse at stream cycle 0; without the macro: err pulse, busy stays 0, no done.
- REQ-024: rst=1 at stream cycle 5 -> all outputs 0 on the next cycle, no done; a new start afterwards completes normally.
- REQ-025: start re-pulsed with different operands during STREAM and WRITE -> ignored; streams still match the first operands.
- REQ-026: Back-to-back: start held high continuously -> a new transaction begins the cycle after FIN, with one idle cycle between done and the next en.

Source files
------------

// File: rtl/unary_stream_gen.sv
// Encodes a binary operand pair into unary (thermometer) streams, then holds a write-out phase.
// Optional UNARY_GEN_SAT_EN: clamp out-of-range operands to LEN instead of rejecting the start.
//
// state  | meaning
// IDLE   | waiting for start, outputs low
// STREAM | LEN cycles of thermometer-coded A/B, read/accumulate mode
// WRITE  | WR_CYC cycles of write-out mode, streams low
// FIN    | one-cycle done pulse, then back to IDLE
module unary_stream_gen #(
    parameter int W      = 4,
    parameter int LEN    = 14,
    parameter int WR_CYC = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_val,
    input  logic [W-1:0] b_val,
    output logic         A,
    output logic         B,
    output logic         en,
    output logic         read_or_write,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int MAXC = (LEN > WR_CYC) ? LEN : WR_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int XW   = (CW > W) ? CW : W;

    localparam logic [W-1:0]  LEN_V       = W'(LEN);
    localparam logic [CW-1:0] STREAM_LAST = CW'(LEN - 1);
    localparam logic [CW-1:0] WRITE_LAST  = CW'(WR_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WRITE  = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [W-1:0]  a_q, b_q, a_nx, b_nx;
    logic          a_oor, b_oor, any_oor;
    logic          A_nx, B_nx, en_nx, rw_nx, busy_nx, done_nx, err_nx;

    assign a_oor   = (a_val > LEN_V);
    assign b_oor   = (b_val > LEN_V);
    assign any_oor = a_oor | b_oor;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            a_q   <= a_nx;
            b_q   <= b_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        a_nx     = a_q;
        b_nx     = b_q;
        err_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    err_nx = any_oor;
`ifdef UNARY_GEN_SAT_EN
                    state_nx = STREAM;
                    cnt_nx   = '0;
                    a_nx     = a_oor ? LEN_V : a_val;
                    b_nx     = b_oor ? LEN_V : b_val;
`else
                    if (!any_oor) begin
                        state_nx = STREAM;
                        cnt_nx   = '0;
                        a_nx     = a_val;
                        b_nx     = b_val;
                    end
`endif
                end
            end
            STREAM: begin
                if (cnt == STREAM_LAST) begin
                    state_nx = WRITE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WRITE: begin
                if (cnt == WRITE_LAST) begin
                    state_nx = FIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            FIN: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        A_nx    = (state_nx == STREAM) && (XW'(cnt_nx) < XW'(a_nx));
        B_nx    = (state_nx == STREAM) && (XW'(cnt_nx) < XW'(b_nx));
        en_nx   = (state_nx == STREAM) || (state_nx == WRITE);
        rw_nx   = (state_nx == WRITE);
        busy_nx = (state_nx == STREAM) || (state_nx == WRITE);
        done_nx = (state_nx == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            A             <= 1'b0;
            B             <= 1'b0;
            en            <= 1'b0;
            read_or_write <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            A             <= A_nx;
            B             <= B_nx;
            en            <= en_nx;
            read_or_write <= rw_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            err           <= err_nx;
        end
    end

endmodule

// File: tb/tb_unary_stream_gen.sv
// Directed, table-driven bench for unary_stream_gen (LEN=14, WR_CYC=20).
// Output vector order in every comparison: {A, B, en, read_or_write, busy, done, err}.
module tb_unary_stream_gen;

    localparam int W      = 4;
    localparam int LEN    = 14;
    localparam int WR_CYC = 20;
    localparam int TOTAL  = LEN + WR_CYC;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_val;
    logic [W-1:0] b_val;
    logic         A, B, en, read_or_write, busy, done, err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unary_stream_gen #(.W(W), .LEN(LEN), .WR_CYC(WR_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .a_val         (a_val),
        .b_val         (b_val),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           ones_a;
        int           ones_b;
        bit           oor;
        bit           repulse;
        string        name;
    } vec_t;

    function automatic logic [6:0] exp_vec(int c, int oa, int ob, bit oor);
        logic xa, xb, xen, xrw, xbusy, xdone, xerr;
        xa = 0; xb = 0; xen = 0; xrw = 0; xbusy = 0; xdone = 0; xerr = 0;
`ifndef UNARY_GEN_SAT_EN
        if (oor) return (c == 0) ? 7'b0000001 : 7'b0000000;
`endif
        if (c < LEN) begin
            xa = (c < oa); xb = (c < ob); xen = 1; xbusy = 1;
        end else if (c < TOTAL) begin
            xen = 1; xrw = 1; xbusy = 1;
        end else if (c == TOTAL) begin
            xdone = 1;
        end
        xerr = oor && (c == 0);
        return {xa, xb, xen, xrw, xbusy, xdone, xerr};
    endfunction

    task automatic compare(string name, int c, logic [6:0] expv);
        logic [6:0] got;
        got = {A, B, en, read_or_write, busy, done, err};
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, c, got, expv);
        end
    endtask

    // Caller has driven start with the operands; the next rising edge is the start edge.
    task automatic check_txn(string name, int oa, int ob, bit oor, bit repulse, bit hold);
        for (int c = 0; c <= TOTAL + 1; c++) begin
            @(negedge clk);
            compare(name, c, exp_vec(c, oa, ob, oor));
            if (hold) begin
                start = 1'b1;
            end else begin
                a_val = W'(c * 5);
                b_val = W'(15 - c);
                start = repulse && (c == 3 || c == LEN + 2 || c == TOTAL);
            end
        end
        start = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{a: 4'd13, b: 4'd14, ones_a: 13, ones_b: 14, oor: 0, repulse: 0, name: "a13_b14"};
        vecs[1] = '{a: 4'd0,  b: 4'd0,  ones_a: 0,  ones_b: 0,  oor: 0, repulse: 0, name: "a0_b0"};
        vecs[2] = '{a: 4'd14, b: 4'd7,  ones_a: 14, ones_b: 7,  oor: 0, repulse: 0, name: "a14_b7"};
        vecs[3] = '{a: 4'd1,  b: 4'd6,  ones_a: 1,  ones_b: 6,  oor: 0, repulse: 1, name: "repulse_a1_b6"};
        vecs[4] = '{a: 4'd15, b: 4'd3,  ones_a: 14, ones_b: 3,  oor: 1, repulse: 0, name: "oor_a15_b3"};
        vecs[5] = '{a: 4'd2,  b: 4'd15, ones_a: 2,  ones_b: 14, oor: 1, repulse: 0, name: "oor_a2_b15"};

        rst   = 1'b1;
        start = 1'b1;
        a_val = 4'd5;
        b_val = 4'd5;
        repeat (2) @(negedge clk);
        compare("reset_state", 0, 7'b0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        compare("idle_after_reset", 0, 7'b0);

        for (int i = 0; i < 6; i++) begin
            a_val = vecs[i].a;
            b_val = vecs[i].b;
            start = 1'b1;
            check_txn(vecs[i].name, vecs[i].ones_a, vecs[i].ones_b, vecs[i].oor, vecs[i].repulse, 1'b0);
        end

        // Reset in stream cycle 5, with start asserted alongside it.
        a_val = 4'd10;
        b_val = 4'd10;
        start = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            compare("pre_abort", c, exp_vec(c, 10, 10, 1'b0));
        end
        rst   = 1'b1;
        start = 1'b1;
        a_val = 4'd1;
        b_val = 4'd1;
        @(negedge clk);
        compare("rst_abort", 0, 7'b0);
        rst   = 1'b0;
        start = 1'b0;
        for (int c = 0; c < TOTAL + 4; c++) begin
            @(negedge clk);
            compare("rst_no_done", c, 7'b0);
        end
        a_val = 4'd4;
        b_val = 4'd9;
        start = 1'b1;
        check_txn("after_abort", 4, 9, 1'b0, 1'b0, 1'b0);

        // Start held high: the second transaction follows one idle cycle after done.
        a_val = 4'd2;
        b_val = 4'd5;
        start = 1'b1;
        check_txn("b2b_first", 2, 5, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        check_txn("b2b_second", 2, 5, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
